mem_fill_engine: RTL and testbench

Avalon-MM master that sits directly upstream of the 32 K x 32 on-chip RAM and drives its slave port. On a start request it fills a word range with a constant or incrementing pattern. It can optionally read the range back and compare it against the expected data. Used for board-state clearing and RAM self-test before the Nios core is released from `reset_req`.

---
 rtl/mem_fill_pkg.sv | 18 +
 rtl/mem_fill_engine_if.sv | 27 ++
 rtl/mem_fill_checker.sv | 62 ++++++
 rtl/mem_fill_engine.sv | 182 ++++++++++++++++++
 tb/tb_mem_fill_engine.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_fill_pkg.sv
// Shared types and constants for the RAM fill/verify engine.
package mem_fill_pkg;

  localparam int unsigned MEM_WORDS  = 32768;
  localparam int unsigned DEF_ADDR_W = 15;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam logic [3:0]  BE_ALL     = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_VERIFY,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mem_fill_engine_if.sv
// Avalon-MM port between the fill engine (master) and the on-chip RAM (slave).
interface mem_fill_engine_if
  import mem_fill_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] m_address;
  logic [3:0]        m_byteenable;
  logic              m_chipselect;
  logic              m_write;
  logic [DATA_W-1:0] m_writedata;
  logic              m_clken;
  logic [DATA_W-1:0] m_readdata;

  modport master (
    output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
    output m_readdata
  );

endinterface

// File: rtl/mem_fill_checker.sv
// Read-back comparator: aligns expected data/address with the 1-cycle RAM latency,
// counts mismatches (saturating) and captures the first failing address.
module mem_fill_checker
  import mem_fill_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              flush_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [CNT_W-1:0]  err_count_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  logic              vld_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] exp_q;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              miss_c;

  assign miss_c = vld_q && (rdata_i != exp_q);

  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    if (clear_i) begin
      err_cnt_d  = '0;
      err_addr_d = '0;
    end else if (miss_c && !flush_i) begin
      if (err_cnt_q == '0) err_addr_d = addr_q;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q      <= 1'b0;
      addr_q     <= '0;
      exp_q      <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      vld_q      <= issue_i && !flush_i && !clear_i;
      addr_q     <= addr_i;
      exp_q      <= exp_i;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_count_o = err_cnt_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: rtl/mem_fill_engine.sv
// Avalon-MM master that fills a RAM word range with a constant or incrementing
// pattern and optionally reads it back for comparison.
module mem_fill_engine
  import mem_fill_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [DATA_W-1:0] pattern,
  input  logic              incr_mode,
  input  logic              verify,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] err_addr,
  mem_fill_engine_if.master m
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MEM_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [DATA_W-1:0] pat_q, pat_d, wdata_q, wdata_d;
  logic              incr_q, incr_d, ver_q, ver_d;
  logic              cs_q, cs_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d;
  logic              launch_c, flush_c, last_c;
  logic [CNT_W-1:0]  clamp_c;
  logic [ADDR_W-1:0] seq_addr_c;
  logic [DATA_W-1:0] seq_data_c;

  assign clamp_c    = (word_count > MAX_CNT) ? MAX_CNT : word_count;
  assign last_c     = (idx_q == cnt_q);
  assign seq_addr_c = base_q + ADDR_W'(idx_q);
  assign seq_data_c = incr_q ? (pat_q + DATA_W'(idx_q)) : pat_q;

  // Next state and next values of the registered master-port outputs.
  // Index 0 is issued on the transition edge itself, so idx tracks the next index.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    pat_d    = pat_q;
    incr_d   = incr_q;
    ver_d    = ver_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cs_d     = 1'b0;
    wr_d     = 1'b0;
    launch_c = 1'b0;
    flush_c  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      flush_c = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            launch_c = 1'b1;
            base_d   = base_addr;
            cnt_d    = clamp_c;
            pat_d    = pattern;
            incr_d   = incr_mode;
            ver_d    = verify;
            idx_d    = '0;
            if (clamp_c == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_FILL;
              cs_d    = 1'b1;
              wr_d    = 1'b1;
              addr_d  = base_addr;
              wdata_d = pattern;
              idx_d   = CNT_W'(1);
            end
          end
        end
        ST_FILL: begin
          if (!last_c) begin
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            addr_d  = seq_addr_c;
            wdata_d = seq_data_c;
            idx_d   = idx_q + CNT_W'(1);
          end else if (ver_q) begin
            state_d = ST_VERIFY;
            cs_d    = 1'b1;
            addr_d  = base_q;
            wdata_d = pat_q;
            idx_d   = CNT_W'(1);
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_VERIFY: begin
          if (!last_c) begin
            cs_d    = 1'b1;
            addr_d  = seq_addr_c;
            wdata_d = seq_data_c;
            idx_d   = idx_q + CNT_W'(1);
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign busy_d = (state_d == ST_FILL) || (state_d == ST_VERIFY) || (state_d == ST_DRAIN);
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      pat_q   <= '0;
      incr_q  <= 1'b0;
      ver_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      pat_q   <= pat_d;
      incr_q  <= incr_d;
      ver_q   <= ver_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Compare data rides on the write-data register during reads.
  mem_fill_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_checker (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (launch_c),
    .flush_i     (flush_c),
    .issue_i     (cs_q && !wr_q),
    .addr_i      (addr_q),
    .exp_i       (wdata_q),
    .rdata_i     (m.m_readdata),
    .err_count_o (err_count),
    .err_addr_o  (err_addr)
  );

  assign busy           = busy_q;
  assign done           = done_q;
  assign m.m_address    = addr_q;
  assign m.m_writedata  = wdata_q;
  assign m.m_chipselect = cs_q;
  assign m.m_write      = wr_q;
  assign m.m_byteenable = BE_ALL;
  assign m.m_clken      = 1'b1;

endmodule

// File: tb/tb_mem_fill_engine.sv
// Directed bench for mem_fill_engine with a 1-cycle-latency RAM model.
module tb_mem_fill_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, incr_mode, verify;
  logic [14:0] base_addr;
  logic [15:0] word_count;
  logic [31:0] pattern;
  logic        busy, done;
  logic [15:0] err_count;
  logic [14:0] err_addr;

  always #5 clk = ~clk;

  mem_fill_engine_if #(.ADDR_W(15), .DATA_W(32)) bus ();

  mem_fill_engine #(.ADDR_W(15), .DATA_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .word_count (word_count),
    .pattern    (pattern),
    .incr_mode  (incr_mode),
    .verify     (verify),
    .busy       (busy),
    .done       (done),
    .err_count  (err_count),
    .err_addr   (err_addr),
    .m          (bus)
  );

  // RAM model with optional forced-zero read words
  logic [31:0] mem [0:32767];
  logic        fe0 = 1'b0, fe1 = 1'b0;
  logic [14:0] fa0 = '0, fa1 = '0;

  always @(posedge clk) begin
    if (bus.m_chipselect && bus.m_write) mem[bus.m_address] <= bus.m_writedata;
    if (bus.m_chipselect && !bus.m_write)
      bus.m_readdata <= ((fe0 && bus.m_address == fa0) || (fe1 && bus.m_address == fa1))
                        ? 32'h0 : mem[bus.m_address];
  end

  int          checks = 0;
  int          errors = 0;
  logic [14:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          wr_j[$];
  int          rd_n;
  logic        busy_before, post_abort_busy, post_abort_cs;
  int          d;
  logic [14:0] exp_a[4];
  logic [31:0] exp_dv[4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [14:0] b, input logic [15:0] n, input logic [31:0] p,
                        input logic inc, input logic ver);
    @(negedge clk);
    base_addr  = b;
    word_count = n;
    pattern    = p;
    incr_mode  = inc;
    verify     = ver;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Called in cycle k+1; j counts cycles after the start edge.
  task automatic run(input int limit, input int abort_at, input int start_at, output int done_at);
    done_at = -1;
    wr_a.delete(); wr_d.delete(); wr_j.delete();
    rd_n = 0;
    busy_before = 1'b0;
    for (int j = 1; j <= limit; j++) begin
      if (j > 1) @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      if (bus.m_chipselect && bus.m_write) begin
        wr_a.push_back(bus.m_address);
        wr_d.push_back(bus.m_writedata);
        wr_j.push_back(j);
      end
      if (bus.m_chipselect && !bus.m_write) rd_n++;
      if (j == abort_at + 1) begin
        post_abort_busy = busy;
        post_abort_cs   = bus.m_chipselect;
      end
      if (done) begin
        done_at = j;
        break;
      end
      busy_before = busy;
      if (j == abort_at) abort = 1'b1;
      if (j == start_at) begin
        start      = 1'b1;
        base_addr  = 15'h0040;
        word_count = 16'd1;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; incr_mode = 1'b0; verify = 1'b0;
    base_addr = '0; word_count = '0; pattern = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cs", bus.m_chipselect, 0);
    check("rst_wr", bus.m_write, 0);
    check("rst_addr", bus.m_address, 0);
    check("rst_wdata", bus.m_writedata, 0);
    check("rst_err", err_count, 0);
    check("rst_eaddr", err_addr, 0);
    check("rst_be", bus.m_byteenable, 4'hF);
    check("rst_clken", bus.m_clken, 1);
    @(negedge clk);
    reset = 1'b0;

    // Constant fill with verify
    launch(15'h0010, 16'd4, 32'hA5A5A5A5, 1'b0, 1'b1);
    run(40, 0, 0, d);
    check("s1_done_at", d, 10);
    check("s1_nwr", wr_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("s1_addr", wr_a[i], 15'h0010 + 15'(i));
      check("s1_data", wr_d[i], 32'hA5A5A5A5);
    end
    check("s1_first_j", wr_j[0], 1);
    check("s1_last_j", wr_j[3], 4);
    check("s1_nrd", rd_n, 4);
    check("s1_err", err_count, 0);
    check("s1_busy_before", busy_before, 1);
    check("s1_busy_at_done", busy, 0);

    // Incrementing fill across the address wrap
    exp_a  = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    exp_dv = '{32'h100, 32'h101, 32'h102, 32'h103};
    launch(15'h7FFE, 16'd4, 32'h0000_0100, 1'b1, 1'b1);
    run(40, 0, 0, d);
    check("s2_done_at", d, 10);
    check("s2_nwr", wr_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("s2_addr", wr_a[i], exp_a[i]);
      check("s2_data", wr_d[i], exp_dv[i]);
    end
    check("s2_err", err_count, 0);

    // One forced bad word
    fe0 = 1'b1; fa0 = 15'h0012;
    launch(15'h0010, 16'd4, 32'hA5A5A5A5, 1'b0, 1'b1);
    run(40, 0, 0, d);
    check("s3a_done_at", d, 10);
    check("s3a_err", err_count, 1);
    check("s3a_eaddr", err_addr, 15'h0012);

    // Two forced bad words: first address sticks
    fe1 = 1'b1; fa1 = 15'h0013;
    launch(15'h0010, 16'd4, 32'hA5A5A5A5, 1'b0, 1'b1);
    run(40, 0, 0, d);
    check("s3b_err", err_count, 2);
    check("s3b_eaddr", err_addr, 15'h0012);
    fe0 = 1'b0; fe1 = 1'b0;

    // Zero count
    launch(15'h0055, 16'd0, 32'h1, 1'b0, 1'b1);
    run(10, 0, 0, d);
    check("s4_done_at", d, 1);
    check("s4_ncs", wr_a.size() + rd_n, 0);
    check("s4_err_cleared", err_count, 0);

    // Oversized count clamps to the full RAM
    launch(15'h1234, 16'hFFFF, 32'hDEAD0000, 1'b1, 1'b0);
    run(33000, 0, 0, d);
    check("s5_done_at", d, 32769);
    check("s5_nwr", wr_a.size(), 32768);
    check("s5_first_addr", wr_a[0], 15'h1234);
    check("s5_wrap_addr", wr_a[28108], 15'h0000);
    check("s5_last_addr", wr_a[32767], 15'h1233);
    check("s5_last_data", wr_d[32767], 32'hDEAD7FFF);

    // Abort during fill
    launch(15'h0020, 16'd8, 32'h77, 1'b0, 1'b1);
    run(20, 3, 0, d);
    check("s6_no_done", d, -1);
    check("s6_nwr", wr_a.size(), 3);
    check("s6_busy_k4", post_abort_busy, 0);
    check("s6_cs_k4", post_abort_cs, 0);

    // Start pulse while busy is ignored
    launch(15'h0010, 16'd4, 32'hA5A5A5A5, 1'b0, 1'b1);
    run(40, 0, 2, d);
    check("s7_done_at", d, 10);
    check("s7_nwr", wr_a.size(), 4);
    check("s7_addr1", wr_a[1], 15'h0011);
    check("s7_addr3", wr_a[3], 15'h0013);

    // Async reset mid-verify
    launch(15'h0010, 16'd4, 32'hA5A5A5A5, 1'b0, 1'b1);
    run(6, 0, 0, d);
    check("s8_pre_read", bus.m_chipselect && !bus.m_write, 1);
    #1 reset = 1'b1;
    #1;
    check("s8_cs", bus.m_chipselect, 0);
    check("s8_wr", bus.m_write, 0);
    check("s8_addr", bus.m_address, 0);
    check("s8_wdata", bus.m_writedata, 0);
    check("s8_busy", busy, 0);
    check("s8_done", done, 0);
    check("s8_err", err_count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
